// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives instruction memory and queues {pc, instr} toward decode.
// Latency: a pushed entry reaches out_* one cycle later (same cycle if FETCH_QUEUE_BYPASS_EN and the queue is empty).
// Backpressure: out_valid/out_ready to decode; a full queue stops pushes and holds the PC.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue bypass of the fetched word to out_*).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_pc                      fetch PC to instruction memory (the pc register)
//   imem_instr, imem_valid       returned instruction word for imem_pc
//   redirect_valid, redirect_pc  PC reload request; flushes the queue
//   out_valid, out_ready         handshake toward decode
//   out_pc, out_instr            head entry
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]      pc;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   full;
  logic   empty;
  logic   push_ok;
  logic   wr_en;
  logic   pop;
  logic   bypass_take;
  entry_t head;

  assign imem_pc = pc;

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    // Occupancy is judged at the start of the cycle: a same-cycle pop does not open a slot.
    push_ok = imem_valid && !full && !redirect_valid && !rst;
    head    = mem[rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the word coming back from memory directly.
    out_valid   = (!empty || push_ok) && !redirect_valid;
    out_pc      = empty && push_ok ? pc         : head.pc;
    out_instr   = empty && push_ok ? imem_instr : head.instr;
    bypass_take = empty && push_ok && out_ready;
`else
    out_valid   = !empty && !redirect_valid;
    out_pc      = head.pc;
    out_instr   = head.instr;
    bypass_take = 1'b0;
`endif
    // A consumed bypass word is never written; storage pops only when it holds something.
    wr_en = push_ok && !bypass_take;
    pop   = out_valid && out_ready && !empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: everything fetched on the old path is dropped.
      pc     <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        pc <= pc + 32'd4;
      end
      if (wr_en) begin
        mem[wr_ptr] <= {pc, imem_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver predicts each fetched {pc, instr} into a queue,
// a negedge monitor pops it whenever decode accepts an entry and compares.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = '0;
  logic        imem_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .imem_valid(imem_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the architectural fetch PC and the ordered list of words decode must still see.
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] exp_q[$];
  logic        exp_ov  = 1'b0;
  logic [31:0] exp_ipc = RESET_PC;
  bit          mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and advance the reference model to the state after that cycle.
  task automatic drive(input logic r, input logic iv, input logic rv,
                       input logic [31:0] rpc, input logic ordy);
    bit push;
    @(posedge clk);
    #1;
    rst            = r;
    imem_valid     = iv;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_instr     = $urandom;
    exp_ipc        = m_pc;
    if (r) begin
      exp_ov = 1'b0;
      m_pc   = RESET_PC;
      exp_q.delete();
    end else if (rv) begin
      exp_ov = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
      exp_q.delete();
    end else begin
      push   = iv && (exp_q.size() < DEPTH);
      exp_ov = (exp_q.size() > 0) || (BYP && push);
      if (push) begin
        exp_q.push_back({m_pc, imem_instr});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Monitor: every accepted entry must be the oldest outstanding prediction.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("imem_pc", imem_pc, exp_ipc);
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'd1, 32'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e[63:32]);
          chk("out_instr", out_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_imem_pc", imem_pc, RESET_PC);
    mon_en = 1'b1;

    // Fill with decode stalled: PC stops at 0x10 and the head stays at 0x0.
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("fill_imem_pc", imem_pc, 32'h10);
    chk("fill_head_pc", out_pc, 32'h0);
    // Drain in order, then stream with both sides open.
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (8) drive(1'b0, 1'b1, 1'b0, '0, 1'b1);

    // Redirect with entries queued, to a misaligned target.
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b1);
    @(negedge clk);
    chk("redir_flush_valid", {31'b0, out_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("redir_imem_pc", imem_pc, 32'h200);
    repeat (4) drive(1'b0, 1'b1, 1'b0, '0, 1'b1);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF5, 1'b0);
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0, $urandom_range(0, 1) == 1);

    // Reset with entries queued.
    repeat (3) drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_imem_pc", imem_pc, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 2) != 0);
    end

    // Drain: nothing predicted may be left undelivered.
    repeat (DEPTH + 2) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
